// File: rtl/branch_predictor_pkg.sv
// Shared types for the bimodal direction / BTB predictor.
// FSM states, 2-bit counter encodings and a direction helper.
package branch_predictor_pkg;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  function automatic logic ctr_taken(
    input logic [1:0] c
  );
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit up/down saturating counter next-state (combinational).
// Ports: ctr (current), up (1=increment), nxt (next value).
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    unique case (1'b1)
      up && (ctr != CTR_ST):
        nxt = ctr + 2'd1;
      !up && (ctr != CTR_SNT):
        nxt = ctr - 2'd1;
      default:
        nxt = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter table plus direct-mapped BTB; IF lookup, EX train.
// Ports: clk, reset (sync, active-low), if_pc lookup, EX update, perf counts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_BITS = 6,
  parameter int         TAG_BITS = 8,
  parameter logic [1:0] CTR_INIT = CTR_WNT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        branch_estimation,
  output logic [31:0] predicted_target,
  output logic        btb_hit,
  output logic        ready,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_prediction_miss,
  output logic [31:0] branch_count,
  output logic [31:0] miss_count
);

  localparam int N  = 2**IDX_BITS;
  localparam int TL = IDX_BITS + 2;
  localparam int TH = IDX_BITS + TAG_BITS + 1;

  bp_state_e           state_q;
  bp_state_e           state_d;
  logic [IDX_BITS-1:0] init_idx_q;
  logic [IDX_BITS-1:0] init_idx_d;
  logic [31:0]         bc_q;
  logic [31:0]         bc_d;
  logic [31:0]         mc_q;
  logic [31:0]         mc_d;

  logic [1:0]          ctr_q [N];
  logic                vld_q [N];
  logic [TAG_BITS-1:0] tag_q [N];
  logic [31:0]         tgt_q [N];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] wr_tag;
  logic                rdy;
  logic                hit;
  logic [1:0]          ctr_nxt;
  logic                unused_pc;

  assign rd_idx    = if_pc[IDX_BITS+1:2];
  assign rd_tag    = if_pc[TH:TL];
  assign wr_idx    = ex_pc[IDX_BITS+1:2];
  assign wr_tag    = ex_pc[TH:TL];
  assign unused_pc = ^{if_pc, ex_pc};

  assign rdy = (state_q == BP_READY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      bc_q       <= '0;
      mc_q       <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      bc_q       <= bc_d;
      mc_q       <= mc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    bc_d       = bc_q;
    mc_d       = mc_q;
    unique case (state_q)
      BP_INIT: begin
        init_idx_d = init_idx_q + IDX_BITS'(1);
        if (init_idx_q == IDX_BITS'(N-1))
          state_d = BP_READY;
      end
      BP_READY: begin
        bc_d = bc_q + 32'(ex_branch);
        mc_d = mc_q
             + 32'(ex_branch & ex_prediction_miss);
      end
    endcase
  end

  branch_predictor_sat_counter2 u_sat (
    .ctr (ctr_q[wr_idx]),
    .up  (ex_branch_taken),
    .nxt (ctr_nxt)
  );

  // Single write port: the sweep owns it in INIT, EX in READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (!rdy) begin
        ctr_q[init_idx_q] <= CTR_INIT;
        vld_q[init_idx_q] <= 1'b0;
      end else if (ex_branch) begin
        ctr_q[wr_idx] <= ctr_nxt;
        if (ex_branch_taken) begin
          vld_q[wr_idx] <= 1'b1;
          tag_q[wr_idx] <= wr_tag;
          tgt_q[wr_idx] <= ex_branch_target;
        end
      end
    end
  end

  assign hit = rdy & vld_q[rd_idx]
             & (tag_q[rd_idx] == rd_tag);

  assign btb_hit           = hit;
  assign branch_estimation = hit
                           & ctr_taken(ctr_q[rd_idx]);
  assign predicted_target  = hit ? tgt_q[rd_idx] : '0;
  assign ready             = rdy;
  assign branch_count      = bc_q;
  assign miss_count        = mc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed cases plus
// random traffic against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        branch_estimation;
  logic [31:0] predicted_target;
  logic        btb_hit;
  logic        ready;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        ex_prediction_miss;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                (clk),
    .reset              (reset),
    .if_pc              (if_pc),
    .branch_estimation  (branch_estimation),
    .predicted_target   (predicted_target),
    .btb_hit            (btb_hit),
    .ready              (ready),
    .ex_branch          (ex_branch),
    .ex_pc              (ex_pc),
    .ex_branch_taken    (ex_branch_taken),
    .ex_branch_target   (ex_branch_target),
    .ex_prediction_miss (ex_prediction_miss),
    .branch_count       (branch_count),
    .miss_count         (miss_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arrays indexed by pc/4 mod 64.
  int          m_ctr [64];
  bit          m_vld [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  bit          m_ready;
  int          m_sweep;
  int unsigned m_bc;
  int unsigned m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic model_update();
    int j;
    if (!reset) begin
      m_ready = 0;
      m_sweep = 0;
      m_bc    = 0;
      m_mc    = 0;
    end else if (!m_ready) begin
      m_ctr[m_sweep] = 1;
      m_vld[m_sweep] = 0;
      m_sweep++;
      if (m_sweep == 64) m_ready = 1;
    end else if (ex_branch) begin
      j = idx_of(ex_pc);
      if (ex_branch_taken) begin
        if (m_ctr[j] < 3) m_ctr[j]++;
        m_vld[j] = 1;
        m_tag[j] = tag_of(ex_pc);
        m_tgt[j] = ex_branch_target;
      end else if (m_ctr[j] > 0) begin
        m_ctr[j]--;
      end
      m_bc++;
      if (ex_prediction_miss) m_mc++;
    end
  endtask

  task automatic check_model();
    int  i;
    bit  h;
    i = idx_of(if_pc);
    h = m_ready && m_vld[i] && (m_tag[i] == tag_of(if_pc));
    check("m_ready", 32'(ready), 32'(m_ready));
    check("m_hit", 32'(btb_hit), 32'(h));
    check("m_est", 32'(branch_estimation),
          32'(h && m_ctr[i] >= 2));
    check("m_tgt", predicted_target, h ? m_tgt[i] : 32'h0);
    check("m_bcnt", branch_count, m_bc);
    check("m_mcnt", miss_count, m_mc);
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic br(
    input logic [31:0] pc,
    input logic        tk,
    input logic [31:0] tgt,
    input logic        miss
  );
    ex_branch          = 1'b1;
    ex_pc              = pc;
    ex_branch_taken    = tk;
    ex_branch_target   = tgt;
    ex_prediction_miss = miss;
    tick();
    ex_branch          = 1'b0;
    ex_prediction_miss = 1'b0;
  endtask

  task automatic look(
    input string       tag,
    input logic [31:0] pc,
    input logic        e_hit,
    input logic        e_est
  );
    if_pc = pc;
    @(negedge clk);
    check_model();
    check({tag, "_hit"}, 32'(btb_hit), 32'(e_hit));
    check({tag, "_est"}, 32'(branch_estimation), 32'(e_est));
    to_pos();
  endtask

  task automatic rand_ex();
    ex_branch          = 1'($urandom);
    ex_pc              = $urandom;
    ex_branch_taken    = 1'($urandom);
    ex_branch_target   = $urandom;
    ex_prediction_miss = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] small_pc();
    return (32'($urandom_range(0, 3)) << 8)
         | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int n;
    reset              = 1'b0;
    if_pc              = 32'h0;
    ex_branch          = 1'b0;
    ex_pc              = 32'h0;
    ex_branch_taken    = 1'b0;
    ex_branch_target   = 32'h0;
    ex_prediction_miss = 1'b0;
    to_pos();
    to_pos();
    reset = 1'b1;

    // Sweep: 64 cycles not ready, EX traffic ignored.
    for (int k = 0; k < 64; k++) begin
      if_pc = $urandom;
      rand_ex();
      @(negedge clk);
      check_model();
      check("init_ready", 32'(ready), 32'h0);
      check("init_est", 32'(branch_estimation), 32'h0);
      to_pos();
    end
    ex_branch = 1'b0;
    @(negedge clk);
    check_model();
    check("ready_up", 32'(ready), 32'h1);
    check("sweep_bcnt", branch_count, 32'h0);
    to_pos();

    // Allocate and predict.
    br(32'h100, 1'b1, 32'h140, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1);
    check("alloc_tgt", predicted_target, 32'h140);

    // Saturation walk (counter now 2).
    repeat (3) br(32'h100, 1'b1, 32'h140, 1'b0);
    br(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_nt1", 32'h100, 1'b1, 1'b1);
    repeat (2) br(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_nt3", 32'h100, 1'b1, 1'b0);
    repeat (2) br(32'h100, 1'b0, 32'h0, 1'b0);
    br(32'h100, 1'b1, 32'h140, 1'b0);
    look("floor_t1", 32'h100, 1'b1, 1'b0);
    br(32'h100, 1'b1, 32'h140, 1'b0);
    look("floor_t2", 32'h100, 1'b1, 1'b1);

    // Aliasing: same index, other tag.
    look("alias", 32'h4100, 1'b0, 1'b0);
    br(32'h4100, 1'b0, 32'h0, 1'b0);
    look("alias_ctr", 32'h100, 1'b1, 1'b0);

    // Same-cycle write to looked-up index: old value seen.
    if_pc = 32'h200;
    br(32'h200, 1'b1, 32'h300, 1'b0);
    look("bypass", 32'h200, 1'b1, 1'b1);

    // Perf counters from a clean reset.
    do_reset();
    repeat (64) tick();
    for (int k = 0; k < 10; k++)
      br($urandom, 1'($urandom), $urandom, 1'(k % 4 == 1));
    ex_prediction_miss = 1'b1;
    repeat (2) tick();
    ex_prediction_miss = 1'b0;
    @(negedge clk);
    check("perf_bcnt", branch_count, 32'd10);
    check("perf_mcnt", miss_count, 32'd3);
    to_pos();

    // Random traffic with a small PC pool for frequent hits.
    for (int k = 0; k < 3000; k++) begin
      if_pc = small_pc();
      rand_ex();
      ex_pc = small_pc();
      tick();
    end
    ex_branch = 1'b0;

    // Reset mid-sweep at cycle 30.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      rand_ex();
      tick();
    end
    do_reset();
    n = 0;
    while (n < 200) begin
      rand_ex();
      if_pc = $urandom;
      @(negedge clk);
      check_model();
      if (ready) break;
      to_pos();
      n++;
    end
    check("restart_len", 32'(n), 32'd64);
    check("restart_bcnt", branch_count, 32'h0);
    check("restart_mcnt", miss_count, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
